// File: rtl/irq_pkg.sv
// Shared types and sizing helpers for the external interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;

  localparam int unsigned N_SRC_DEF = 4;

  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the eligible request vector.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned ID_W  = id_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Walk from the top so the lowest set index is the last to write.
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge detect, pending/overrun latches, and a
// single-outstanding request/service handshake towards the core.
module ext_irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned ID_W  = id_w(N_SRC)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ExtIAck,
  input  logic             ERet,
  input  logic             ovr_clr,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic             irq_active,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] overrun
);

  irq_state_t       r_state, w_state_d;
  logic [N_SRC-1:0] r_prev, r_pending, r_overrun;
  logic             r_irq, w_irq_d;
  logic [ID_W-1:0]  r_id, w_id_d;

  logic [N_SRC-1:0] w_rise, w_ack_vec, w_pending_d, w_overrun_d;
  logic             w_ack, w_any;
  logic [ID_W-1:0]  w_idx;

  assign w_rise = irq_src & ~r_prev;
  assign w_ack  = (r_state == REQ) && ExtIAck;

  always_comb begin
    w_ack_vec = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      w_ack_vec[i] = w_ack && (r_id == ID_W'(i));
    end
  end

  // A rising edge beats a same-cycle acknowledge or clear.
  assign w_pending_d = (r_pending & ~w_ack_vec) | w_rise;
  assign w_overrun_d = (ovr_clr ? '0 : r_overrun) | (w_rise & r_pending);

  irq_prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req (r_pending & irq_mask),
    .any (w_any),
    .idx (w_idx)
  );

  always_comb begin
    w_state_d = r_state;
    w_irq_d   = r_irq;
    w_id_d    = r_id;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_id_d    = w_idx;
          w_irq_d   = 1'b1;
          w_state_d = REQ;
        end
      end
      REQ: begin
        if (ExtIAck) begin
          w_irq_d   = 1'b0;
          w_state_d = SERVICE;
        end
      end
      SERVICE: begin
        if (ERet) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_prev    <= irq_src;
      r_pending <= '0;
      r_overrun <= '0;
      r_irq     <= 1'b0;
      r_id      <= '0;
    end else begin
      r_state   <= w_state_d;
      r_prev    <= irq_src;
      r_pending <= w_pending_d;
      r_overrun <= w_overrun_d;
      r_irq     <= w_irq_d;
      r_id      <= w_id_d;
    end
  end

  assign ExtIRQ     = r_irq;
  assign irq_id     = r_id;
  assign irq_active = (r_state == SERVICE);
  assign pending    = r_pending;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed, table-driven bench for ext_irq_ctrl with N_SRC = 4.
module tb_ext_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src, irq_mask;
  logic       ExtIAck, ERet, ovr_clr;
  logic       ExtIRQ, irq_active;
  logic [1:0] irq_id;
  logic [3:0] pending, overrun;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ext_irq_ctrl #(
    .N_SRC (4),
    .ID_W  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .irq_mask   (irq_mask),
    .ExtIAck    (ExtIAck),
    .ERet       (ERet),
    .ovr_clr    (ovr_clr),
    .ExtIRQ     (ExtIRQ),
    .irq_id     (irq_id),
    .irq_active (irq_active),
    .pending    (pending),
    .overrun    (overrun)
  );

  typedef struct {
    logic [3:0] src;
    logic [3:0] mask;
    logic       ack;
    logic       eret;
    logic       clr;
    logic       e_irq;
    logic [1:0] e_id;
    logic       e_act;
    logic [3:0] e_pend;
    logic [3:0] e_ovr;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic [3:0] src, input logic [3:0] mask, input logic ack,
                              input logic eret, input logic clr, input logic e_irq,
                              input logic [1:0] e_id, input logic e_act,
                              input logic [3:0] e_pend, input logic [3:0] e_ovr);
    vec_t v;
    v.src = src; v.mask = mask; v.ack = ack; v.eret = eret; v.clr = clr;
    v.e_irq = e_irq; v.e_id = e_id; v.e_act = e_act; v.e_pend = e_pend; v.e_ovr = e_ovr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check_all(input string tag, input logic e_irq, input logic [1:0] e_id,
                           input logic e_act, input logic [3:0] e_pend, input logic [3:0] e_ovr);
    check({tag, ".ExtIRQ"}, 32'(ExtIRQ), 32'(e_irq));
    check({tag, ".irq_id"}, 32'(irq_id), 32'(e_id));
    check({tag, ".irq_active"}, 32'(irq_active), 32'(e_act));
    check({tag, ".pending"}, 32'(pending), 32'(e_pend));
    check({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled likewise.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             src     mask    ack  eret clr  irq  id  act pend    ovr
    vecs[0]  = mk(4'b0100, 4'hF, 0, 0, 0, 0, 2'd0, 0, 4'b0100, 4'b0000);
    vecs[1]  = mk(4'b0000, 4'hF, 0, 0, 0, 1, 2'd2, 0, 4'b0100, 4'b0000);
    vecs[2]  = mk(4'b0000, 4'hF, 1, 0, 0, 0, 2'd2, 1, 4'b0000, 4'b0000);
    vecs[3]  = mk(4'b0000, 4'hF, 0, 0, 0, 0, 2'd2, 1, 4'b0000, 4'b0000);
    vecs[4]  = mk(4'b0000, 4'hF, 0, 1, 0, 0, 2'd2, 0, 4'b0000, 4'b0000);
    vecs[5]  = mk(4'b1010, 4'hF, 0, 0, 0, 0, 2'd2, 0, 4'b1010, 4'b0000);
    vecs[6]  = mk(4'b0000, 4'hF, 0, 0, 0, 1, 2'd1, 0, 4'b1010, 4'b0000);
    vecs[7]  = mk(4'b0000, 4'hF, 1, 0, 0, 0, 2'd1, 1, 4'b1000, 4'b0000);
    vecs[8]  = mk(4'b0000, 4'hF, 0, 1, 0, 0, 2'd1, 0, 4'b1000, 4'b0000);
    vecs[9]  = mk(4'b0000, 4'hF, 0, 0, 0, 1, 2'd3, 0, 4'b1000, 4'b0000);
    vecs[10] = mk(4'b0000, 4'hF, 1, 0, 0, 0, 2'd3, 1, 4'b0000, 4'b0000);
    vecs[11] = mk(4'b0000, 4'hF, 0, 1, 0, 0, 2'd3, 0, 4'b0000, 4'b0000);
    // masked source 0
    vecs[12] = mk(4'b0001, 4'hE, 0, 0, 0, 0, 2'd3, 0, 4'b0001, 4'b0000);
    vecs[13] = mk(4'b0000, 4'hE, 0, 0, 0, 0, 2'd3, 0, 4'b0001, 4'b0000);
    vecs[14] = mk(4'b0000, 4'hF, 0, 0, 0, 1, 2'd0, 0, 4'b0001, 4'b0000);
    vecs[15] = mk(4'b0000, 4'hF, 1, 0, 0, 0, 2'd0, 1, 4'b0000, 4'b0000);
    vecs[16] = mk(4'b0000, 4'hF, 0, 1, 0, 0, 2'd0, 0, 4'b0000, 4'b0000);
    // overrun on source 1, higher-priority arrival during REQ, set-beats-ack
    vecs[17] = mk(4'b0010, 4'hF, 0, 0, 0, 0, 2'd0, 0, 4'b0010, 4'b0000);
    vecs[18] = mk(4'b0000, 4'hF, 0, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0000);
    vecs[19] = mk(4'b0010, 4'hF, 0, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0010);
    vecs[20] = mk(4'b0001, 4'hF, 0, 0, 0, 1, 2'd1, 0, 4'b0011, 4'b0010);
    vecs[21] = mk(4'b0010, 4'hF, 1, 0, 0, 0, 2'd1, 1, 4'b0011, 4'b0010);
    vecs[22] = mk(4'b0000, 4'hF, 0, 1, 0, 0, 2'd1, 0, 4'b0011, 4'b0010);
    vecs[23] = mk(4'b0000, 4'hF, 0, 0, 1, 1, 2'd0, 0, 4'b0011, 4'b0000);
    vecs[24] = mk(4'b0000, 4'hF, 1, 0, 0, 0, 2'd0, 1, 4'b0010, 4'b0000);
    // stray ack in SERVICE is ignored
    vecs[25] = mk(4'b0000, 4'hF, 1, 0, 0, 0, 2'd0, 1, 4'b0010, 4'b0000);
    vecs[26] = mk(4'b0000, 4'hF, 0, 1, 0, 0, 2'd0, 0, 4'b0010, 4'b0000);
    vecs[27] = mk(4'b0000, 4'hF, 0, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0000);
    vecs[28] = mk(4'b0000, 4'hF, 1, 0, 0, 0, 2'd1, 1, 4'b0000, 4'b0000);

    reset = 1'b1; irq_src = 4'b0100; irq_mask = 4'hF;
    ExtIAck = 1'b0; ERet = 1'b0; ovr_clr = 1'b0;
    tick(); tick();
    check_all("reset", 0, 2'd0, 0, 4'b0000, 4'b0000);

    // source held high through reset must not request
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("held.pending", 32'(pending), 32'h0);
      check("held.ExtIRQ", 32'(ExtIRQ), 32'h0);
    end
    irq_src = 4'b0000;
    tick();

    for (int i = 0; i < NV; i++) begin
      irq_src = vecs[i].src; irq_mask = vecs[i].mask;
      ExtIAck = vecs[i].ack; ERet = vecs[i].eret; ovr_clr = vecs[i].clr;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_irq, vecs[i].e_id, vecs[i].e_act,
                vecs[i].e_pend, vecs[i].e_ovr);
    end
    ExtIAck = 1'b0; ERet = 1'b0; ovr_clr = 1'b0;

    // Now in SERVICE with a fresh pending source 2: reset must drop everything
    irq_src = 4'b0100;
    tick();
    check("presvc.active", 32'(irq_active), 32'h1);
    check("presvc.pending", 32'(pending), 32'h4);
    reset = 1'b1; irq_src = 4'b0000;
    tick();
    check_all("midsvc_reset", 0, 2'd0, 0, 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ERet = c[0]; ExtIAck = ~c[0];
      tick();
      check_all($sformatf("post_reset%0d", c), 0, 2'd0, 0, 4'b0000, 4'b0000);
    end
    ERet = 1'b0; ExtIAck = 1'b0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
